// File: rtl/mem_bus_interface.sv
// Off-chip memory bus front end: posts core writes through a small write buffer and
// serialises reads behind any buffered writes onto a valid/ready bus.
module mem_bus_interface #(
    parameter int AW       = 64,
    parameter int DW       = 64,
    parameter int WB_DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    input  logic          core_read,
    input  logic          core_write,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    output logic          bus_req_valid,
    input  logic          bus_req_ready,
    output logic          bus_req_we,
    output logic [AW-1:0] bus_req_addr,
    output logic [DW-1:0] bus_req_wdata,
    input  logic          bus_resp_valid,
    input  logic [DW-1:0] bus_resp_data
);

    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(WB_DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    typedef enum logic [2:0] {IDLE, DRAIN, RD_REQ, RD_WAIT, RD_DONE} state_t;
    state_t state, state_nxt;

    logic [AW-1:0] wb_addr [WB_DEPTH];
    logic [DW-1:0] wb_data [WB_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] wb_cnt;
    logic          wb_full, wb_empty, draining, read_busy, push, pop;

    assign wb_full   = (wb_cnt == FULL_CNT);
    assign wb_empty  = (wb_cnt == '0);
    assign draining  = ((state == IDLE) || (state == DRAIN)) && !wb_empty;
    // While a read owns the bus the core is stalled, so no new write may enter.
    assign read_busy = (state == DRAIN) || (state == RD_REQ) || (state == RD_WAIT);
    assign push      = core_write && !wb_full && !read_busy;
    assign pop       = draining && bus_req_ready;

    // Gated by reset so every output reads 0 while reset is held, even with strobes high.
    assign core_stall = reset && ((core_write && wb_full) ||
                                  (core_read && (state != RD_DONE)));

    always_comb begin
        bus_req_valid = 1'b0;
        bus_req_we    = 1'b0;
        bus_req_addr  = '0;
        bus_req_wdata = '0;
        if (draining) begin
            bus_req_valid = 1'b1;
            bus_req_we    = 1'b1;
            bus_req_addr  = wb_addr[rd_ptr];
            bus_req_wdata = wb_data[rd_ptr];
        end else if (state == RD_REQ) begin
            bus_req_valid = 1'b1;
            bus_req_addr  = core_addr;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (core_read && !core_write)
                    state_nxt = wb_empty ? RD_REQ : DRAIN;
            end
            DRAIN: begin
                if (wb_empty || (pop && (wb_cnt == ONE_CNT)))
                    state_nxt = RD_REQ;
            end
            RD_REQ: begin
                if (bus_req_ready)
                    state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus_resp_valid)
                    state_nxt = RD_DONE;
            end
            RD_DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wb_cnt     <= '0;
            core_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   wb_cnt <= wb_cnt + 1'b1;
                2'b01:   wb_cnt <= wb_cnt - 1'b1;
                default: ;
            endcase
            if ((state == RD_WAIT) && bus_resp_valid)
                core_rdata <= bus_resp_data;
        end
    end

    // Buffer storage carries data only; occupancy is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (push) begin
            wb_addr[wr_ptr] <= core_addr;
            wb_data[wr_ptr] <= core_wdata;
        end
    end

endmodule
